// File: rtl/decoder_pkg.sv
// decoder_pkg: FSM state encoding and MODE constants shared by decoder_nto2n_seq.
package decoder_pkg;
  typedef enum logic [1:0] {IDLE, DECODE, SCAN} state_t;
  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
endpackage

// File: rtl/decoder_nto2n_seq_dwell_timer.sv
// dwell_timer: loadable down-counter; expire is high while the count sits at zero.
module dwell_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         tick,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : tick ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expire = (cnt_q == '0);
endmodule

// File: rtl/decoder_nto2n_seq.sv
// decoder_nto2n_seq: registered N-to-2**N decoder with a timed one-hot scan mode.
// Define DECODER_SCAN_WRAP_EN to make the scan wrap forever instead of a single sweep.
module decoder_nto2n_seq
  import decoder_pkg::*;
#(
  parameter int N = 3,
  parameter int DWELL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EN,
  input  logic              MODE,
  input  logic [N-1:0]      I,
  input  logic [DWELL_W-1:0] DWELL,
  input  logic              START,
  output logic [2**N-1:0]   D,
  output logic [N-1:0]      IDX,
  output logic              BUSY,
  output logic              DONE
);
  localparam int W = 2**N;
  state_t state_q, state_d;
  logic [W-1:0] d_q, d_d;
  logic [N-1:0] idx_q, idx_d;
  logic busy_q, busy_d, done_q, done_d;
  logic load, tick, expire;
  dwell_timer #(.W(DWELL_W)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(load), .tick(tick), .load_val(DWELL), .expire(expire)
  );
  // Outputs are computed for the next state so they register alongside it.
  always_comb begin
    state_d = state_q;
    d_d = '0;
    idx_d = '0;
    busy_d = 1'b0;
    done_d = 1'b0;
    load = 1'b0;
    tick = 1'b0;
    unique case (state_q)
      IDLE:
        if (EN && MODE == MODE_DECODE) begin
          state_d = DECODE;
          d_d = W'(1) << I;
          idx_d = I;
        end else if (EN && MODE == MODE_SCAN && START) begin
          state_d = SCAN;
          d_d = W'(1);
          busy_d = 1'b1;
          load = 1'b1;
        end
      DECODE:
        if (EN && MODE == MODE_DECODE) begin
          d_d = W'(1) << I;
          idx_d = I;
        end else state_d = IDLE;
      SCAN:
        if (!EN) state_d = IDLE;
        else if (!expire) begin
          tick = 1'b1;
          d_d = d_q;
          idx_d = idx_q;
          busy_d = 1'b1;
        end else if (&idx_q) begin
          done_d = 1'b1;
`ifdef DECODER_SCAN_WRAP_EN
          load = 1'b1;
          d_d = W'(1);
          busy_d = 1'b1;
`else
          state_d = IDLE;
`endif
        end else begin
          load = 1'b1;
          idx_d = idx_q + 1'b1;
          d_d = d_q << 1;
          busy_d = 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      d_q <= '0;
      idx_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q <= d_d;
      idx_q <= idx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  assign D = d_q;
  assign IDX = idx_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// tb_decoder_nto2n_seq: randomized scenarios against an arithmetic reference of decode and scan timing.
module tb_decoder_nto2n_seq;
  localparam int N = 3;
  localparam int DW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, mode = 1'b0, start = 1'b0;
  logic [N-1:0] sel = '0;
  logic [DW-1:0] dwell = '0;
  logic [7:0] d;
  logic [N-1:0] idx;
  logic busy, done;
  int checks = 0, errors = 0;
  logic mon = 1'b0;
`ifdef DECODER_SCAN_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  decoder_nto2n_seq #(.N(N), .DWELL_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .EN(en), .MODE(mode), .I(sel), .DWELL(dwell),
    .START(start), .D(d), .IDX(idx), .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (mon) begin
      checks++;
      if ($countones(d) > 1) begin
        errors++;
        $display("FAIL onehot: D=%h has %0d bits set, required <=1", d, $countones(d));
      end
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_scan(input int dw);
    en = 1'b1; mode = 1'b1; start = 1'b1; dwell = DW'(dw);
    step();
    start = 1'b0;
  endtask

  // Expected index follows from elapsed scan cycles; START/MODE/I are scrambled each cycle.
  task automatic scan_run(input int dw, input int n);
    int sweep = 8 * (dw + 1);
    for (int c = 0; c < n; c++) begin
      int ei = (c % sweep) / (dw + 1);
      logic [7:0] ed = 8'(1 << ei);
      logic edone = WRAP && c > 0 && (c % sweep) == 0;
      checks++;
      if (d !== ed || idx !== N'(ei) || busy !== 1'b1 || done !== edone) begin
        errors++;
        $display("FAIL scan c=%0d dw=%0d: D=%h IDX=%0d BUSY=%b DONE=%b, required D=%h IDX=%0d BUSY=1 DONE=%b",
                 c, dw, d, idx, busy, done, ed, ei, edone);
      end
      start = 1'($urandom); mode = 1'($urandom); sel = N'($urandom);
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    mon = 1'b1;
    checks++;
    if (d !== 8'h00 || idx !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: D=%h IDX=%0d BUSY=%b DONE=%b, required all zero", d, idx, busy, done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    en = 1'b1; mode = 1'b0;
    for (int k = 0; k < 20; k++) begin
      int v = (k < 8) ? k : int'($urandom_range(0, 7));
      sel = N'(v);
      step();
      checks++;
      if (d !== 8'(1 << v) || idx !== N'(v) || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL decode I=%0d: D=%h IDX=%0d BUSY=%b DONE=%b, required D=%h IDX=%0d", v, d, idx, busy, done, 8'(1 << v), v);
      end
    end
    en = 1'b0;
    step();
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL decode_off: D=%h, required 00", d);
    end
  endtask

  task automatic test_scan(input int dw);
    logic [7:0] ed = WRAP ? 8'h01 : 8'h00;
    begin_scan(dw);
    scan_run(dw, 8 * (dw + 1));
    checks++;
    if (done !== 1'b1 || d !== ed || idx !== '0 || busy !== WRAP) begin
      errors++;
      $display("FAIL scan_end dw=%0d: DONE=%b D=%h IDX=%0d BUSY=%b, required DONE=1 D=%h IDX=0 BUSY=%b",
               dw, done, d, idx, busy, ed, WRAP);
    end
    en = 1'b0; start = 1'b0;
    step();
    checks++;
    if (done !== 1'b0 || d !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL scan_after dw=%0d: DONE=%b D=%h BUSY=%b, required 0/00/0", dw, done, d, busy);
    end
  endtask

  task automatic test_abort();
    int dw = $urandom_range(0, 5);
    begin_scan(dw);
    scan_run(dw, 3 * (dw + 1) + int'($urandom_range(0, dw)));
    checks++;
    if (idx !== 3'd3) begin
      errors++;
      $display("FAIL abort_pre: IDX=%0d, required 3", idx);
    end
    en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (d !== 8'h00 || busy !== 1'b0 || idx !== '0 || done !== 1'b0) begin
        errors++;
        $display("FAIL abort k=%0d: D=%h BUSY=%b IDX=%0d DONE=%b, required all zero", k, d, busy, idx, done);
      end
      step();
    end
  endtask

  task automatic test_reset_midscan();
    int dw = $urandom_range(0, 4);
    begin_scan(dw);
    scan_run(dw, 5 * (dw + 1));
    rst_n = 1'b0;
    step();
    checks++;
    if (d !== 8'h00 || busy !== 1'b0 || idx !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_midscan: D=%h BUSY=%b IDX=%0d DONE=%b, required all zero", d, busy, idx, done);
    end
    rst_n = 1'b1; en = 1'b1; mode = 1'b0; sel = 3'd6;
    step();
    checks++;
    if (d !== 8'h40 || idx !== 3'd6) begin
      errors++;
      $display("FAIL reset_release: D=%h IDX=%0d, required D=40 IDX=6", d, idx);
    end
    en = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    en = 1'b1; mode = 1'b0; sel = 3'd2;
    step();
    mode = 1'b1; start = 1'b1; dwell = 4'd1;
    step();
    checks++;
    if (d !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL decode_exit: D=%h BUSY=%b, required 00/0", d, busy);
    end
    step();
    start = 1'b0;
    scan_run(1, 16);
    en = 1'b0;
    step();
  endtask

`ifdef DECODER_SCAN_WRAP_EN
  task automatic test_wrap();
    begin_scan(0);
    scan_run(0, 25);
    en = 1'b0;
    step();
    checks++;
    if (d !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL wrap_stop: D=%h BUSY=%b DONE=%b, required 00/0/0", d, busy, done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_decode();
    test_scan(2);
    test_scan(0);
    test_scan(int'($urandom_range(1, 15)));
    test_abort();
    test_reset_midscan();
    test_back_to_back();
`ifdef DECODER_SCAN_WRAP_EN
    test_wrap();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
